// File: rtl/match_logger_pkg.sv
// rtl/match_logger_pkg.sv - shared defaults for the match event logger slice
package match_logger_pkg;

   localparam int TS_W_DEF  = 16;
   localparam int DEPTH_DEF = 4;
   localparam int CNT_W_DEF = 8;
   localparam int PTR_W     = $clog2(DEPTH_DEF);

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with clear and push-when-full-and-popping
module sync_fifo
   import match_logger_pkg::*;
#(
   parameter int W     = TS_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   clr,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          w_do_pop;
   logic          w_do_push;

   assign empty = (r_level == '0);
   assign full  = (r_level == (AW+1)'(DEPTH));

   // A push into a full FIFO is legal only when the head leaves in the same cycle
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign level = r_level;

endmodule

// File: rtl/match_event_logger.sv
// rtl/match_event_logger.sv - edge-detects detector matches, counts them and queues timestamps
module match_event_logger
   import match_logger_pkg::*;
#(
   parameter int TS_W  = TS_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   d_in,
   input  logic                   clear,
   output logic [TS_W-1:0]        ts_data,
   output logic                   ts_valid,
   input  logic                   ts_ready,
   output logic [CNT_W-1:0]       match_count,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] fifo_level
);

   logic [TS_W-1:0]  r_ts_ctr;
   logic [TS_W-1:0]  r_ts_s;
   logic             r_d_s;
   logic             r_d_p;
   logic [CNT_W-1:0] r_match_count;
   logic             r_overflow;

   logic             w_event;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   // r_ts_s captures the counter alongside d_in, so the stamp is the pre-edge count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ts_ctr <= '0;
         r_ts_s   <= '0;
         r_d_s    <= 1'b0;
         r_d_p    <= 1'b0;
      end else begin
         r_ts_ctr <= r_ts_ctr + TS_W'(1);
         r_ts_s   <= r_ts_ctr;
         r_d_s    <= d_in;
         r_d_p    <= r_d_s;
      end
   end

   assign w_event = r_d_s & ~r_d_p;
   assign w_pop   = ts_ready & ~w_empty & ~clear;
   assign w_push  = w_event & ~clear;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_match_count <= '0;
         r_overflow    <= 1'b0;
      end else if (clear) begin
         r_match_count <= '0;
         r_overflow    <= 1'b0;
      end else begin
         if (w_event && (r_match_count != '1)) begin
            r_match_count <= r_match_count + CNT_W'(1);
         end
         if (w_event && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   sync_fifo #(
      .W     (TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clear),
      .push    (w_push),
      .pop     (w_pop),
      .din     (r_ts_s),
      .dout    (ts_data),
      .level   (fifo_level),
      .full    (w_full),
      .empty   (w_empty)
   );

   assign ts_valid    = ~w_empty;
   assign match_count = r_match_count;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_match_event_logger.sv
// tb/tb_match_event_logger.sv - directed self-checking bench for match_event_logger
module tb_match_event_logger;
   import match_logger_pkg::*;

   localparam int TS_W  = 16;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int LVL_W = PTR_W + 1;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             d_in = 1'b0;
   logic             clear = 1'b0;
   logic             ts_ready = 1'b0;
   logic [TS_W-1:0]  ts_data;
   logic             ts_valid;
   logic [CNT_W-1:0] match_count;
   logic             overflow;
   logic [LVL_W-1:0] fifo_level;

   logic [TS_W-1:0]  m_ts;
   logic [TS_W-1:0]  exp4 [5];
   logic [TS_W-1:0]  s5 [5];
   logic [TS_W-1:0]  t;
   int               n_tests = 0;
   int               n_fail = 0;
   int               guard;

   match_event_logger #(
      .TS_W  (TS_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .d_in        (d_in),
      .clear       (clear),
      .ts_data     (ts_data),
      .ts_valid    (ts_valid),
      .ts_ready    (ts_ready),
      .match_count (match_count),
      .overflow    (overflow),
      .fifo_level  (fifo_level)
   );

   always #5 clk = ~clk;

   // reference free-running counter
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m_ts <= '0;
      else          m_ts <= m_ts + 16'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
   endtask

   initial begin
      // 1: reset held 3 cycles
      cyc(3);
      reset_n = 1'b1;
      cyc(1);
      check("rst_valid", ts_valid, 0);
      check("rst_data", ts_data, 0);
      check("rst_count", match_count, 0);
      check("rst_ovf", overflow, 0);
      check("rst_level", fifo_level, 0);

      // 2: single-cycle pulse sampled at ts_ctr=7
      guard = 0;
      while (m_ts != 16'd7 && guard < 50) begin
         cyc(1);
         guard++;
      end
      check("t2_align", m_ts, 7);
      d_in = 1'b1;
      cyc(1);
      d_in = 1'b0;
      check("t2_no_bypass", ts_valid, 0);
      cyc(1);
      check("t2_valid", ts_valid, 1);
      check("t2_data", ts_data, 7);
      check("t2_count", match_count, 1);
      check("t2_level", fifo_level, 1);
      do_clear();
      check("t2_clr_level", fifo_level, 0);
      check("t2_clr_count", match_count, 0);

      // 3: match held 3 cycles -> one event
      t = m_ts;
      d_in = 1'b1;
      cyc(3);
      d_in = 1'b0;
      cyc(2);
      check("t3_level", fifo_level, 1);
      check("t3_data", ts_data, t);
      check("t3_count", match_count, 1);
      do_clear();

      // 4: five events into a 4-deep FIFO
      for (int i = 0; i < 5; i++) begin
         exp4[i] = m_ts;
         d_in = 1'b1;
         cyc(1);
         d_in = 1'b0;
         cyc(2);
      end
      check("t4_level", fifo_level, 4);
      check("t4_ovf", overflow, 1);
      check("t4_count", match_count, 5);
      ts_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("t4_drain_valid", ts_valid, 1);
         check("t4_drain_data", ts_data, exp4[i]);
         cyc(1);
      end
      check("t4_empty", ts_valid, 0);
      cyc(1);
      check("t4_pop_empty_level", fifo_level, 0);
      ts_ready = 1'b0;
      do_clear();

      // 5: full FIFO, event and pop coincide
      for (int i = 0; i < 4; i++) begin
         s5[i] = m_ts;
         d_in = 1'b1;
         cyc(1);
         d_in = 1'b0;
         cyc(2);
      end
      check("t5_full", fifo_level, 4);
      check("t5_ovf0", overflow, 0);
      s5[4] = m_ts;
      d_in = 1'b1;
      cyc(1);
      d_in = 1'b0;
      ts_ready = 1'b1;
      cyc(1);
      ts_ready = 1'b0;
      check("t5_level", fifo_level, 4);
      check("t5_ovf", overflow, 0);
      check("t5_count", match_count, 5);
      ts_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         check("t5_drain_data", ts_data, s5[i]);
         cyc(1);
      end
      ts_ready = 1'b0;
      check("t5_empty", ts_valid, 0);
      do_clear();

      // 6: count saturation, then clear
      for (int i = 0; i < 260; i++) begin
         d_in = 1'b1;
         cyc(1);
         d_in = 1'b0;
         cyc(1);
      end
      check("t6_sat", match_count, 255);
      check("t6_ovf", overflow, 1);
      check("t6_level", fifo_level, 4);
      do_clear();
      check("t6_clr_count", match_count, 0);
      check("t6_clr_ovf", overflow, 0);
      check("t6_clr_valid", ts_valid, 0);
      check("t6_clr_level", fifo_level, 0);
      t = m_ts;
      d_in = 1'b1;
      cyc(1);
      d_in = 1'b0;
      cyc(1);
      check("t6_ts_running", ts_data, t);
      check("t6_count1", match_count, 1);

      // clear during pending event with match held across it
      d_in = 1'b1;
      cyc(1);
      do_clear();
      cyc(2);
      d_in = 1'b0;
      cyc(1);
      check("clr_hold_count", match_count, 0);
      check("clr_hold_level", fifo_level, 0);

      // async reset with an event in flight
      d_in = 1'b1;
      cyc(1);
      d_in = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("arst_count", match_count, 0);
      check("arst_level", fifo_level, 0);
      check("arst_valid", ts_valid, 0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(2);
      check("arst_inflight_level", fifo_level, 0);
      check("arst_inflight_count", match_count, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
